// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and constants for the UART receiver.
// Optional feature macro: UART_RX_PARITY_EN (adds the even-parity PARITY state).
package uart_pkg;

    localparam int unsigned UART_DIVISOR_DEFAULT = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    // 2-of-3 majority used to decide each serial bit
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // next values: shift the line through two stages
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // synchronizer flops, reset to the idle line level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver with 3-sample majority vote per bit.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data and stop).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned UART_DIVISOR = UART_DIVISOR_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    input  logic       rd_i,
    output logic [7:0] data_o,
    output logic       rx_ready_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned CW   = $clog2(UART_DIVISOR);
    localparam int unsigned HALF = UART_DIVISOR / 2;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_H_M1 = cnt_t'(HALF - 1);
    localparam cnt_t CNT_H    = cnt_t'(HALF);
    localparam cnt_t CNT_H_P1 = cnt_t'(HALF + 1);
    localparam cnt_t CNT_LAST = cnt_t'(UART_DIVISOR - 1);

    logic        rxs;
    logic        rxs_prev_q, rxs_prev_d;
    uart_state_e state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        s0_q, s0_d, s1_q, s1_d;
    logic [7:0]  data_q, data_d;
    logic        ready_q, ready_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        at_last, at_decide, vote;
    logic        deliver, frame_bad, par_ok, par_bad;

    uart_sync u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (rxd_i),
        .q_o    (rxs)
    );

    assign at_last   = (cnt_q == CNT_LAST);
    assign at_decide = (cnt_q == CNT_H_P1);
    assign vote      = majority3(s0_q, s1_q, rxs);

`ifdef UART_RX_PARITY_EN
    logic par_err_q, par_err_d;
    assign par_bad = (state_q == ST_PARITY) && at_decide && (vote != ^shift_q);
    assign par_ok  = !par_err_q;
`else
    assign par_bad = 1'b0;
    assign par_ok  = 1'b1;
`endif

    assign deliver   = (state_q == ST_STOP) && at_decide && vote && par_ok;
    assign frame_bad = ((state_q == ST_STOP) && at_decide && !vote) || par_bad;

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (rxs_prev_q && !rxs) state_d = ST_START;
            ST_START:  if (at_decide && vote) state_d = ST_IDLE;
                       else if (at_last)      state_d = ST_DATA;
`ifdef UART_RX_PARITY_EN
            ST_DATA:   if (at_last && bit_idx_q == 3'd7) state_d = ST_PARITY;
            ST_PARITY: if (at_last) state_d = ST_STOP;
`else
            ST_DATA:   if (at_last && bit_idx_q == 3'd7) state_d = ST_STOP;
`endif
            ST_STOP:   if (at_decide) state_d = vote ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rxs) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // output logic
    always_comb begin
        busy_o = (state_q != ST_IDLE);
    end

    // datapath next values: counter, samples, shift register, delivery and flags
    always_comb begin
        rxs_prev_d = rxs;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        s0_d       = (cnt_q == CNT_H_M1) ? rxs : s0_q;
        s1_d       = (cnt_q == CNT_H)    ? rxs : s1_q;
        data_d     = data_q;
        ready_d    = ready_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;

        // DATA restarts the count per bit; BREAK saturates instead of wrapping
        if (state_d != state_q || (state_q == ST_DATA && at_last))
            cnt_d = '0;
        else if (state_q != ST_IDLE && !at_last)
            cnt_d = cnt_q + cnt_t'(1);

        if (state_q == ST_START)
            bit_idx_d = '0;
        else if (state_q == ST_DATA && at_last)
            bit_idx_d = bit_idx_q + 3'd1;

        if (state_q == ST_DATA && at_decide)
            shift_d = {vote, shift_q[7:1]};

        // rd clears first so a same-cycle delivery or error still lands
        if (rd_i) begin
            ready_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
        if (deliver) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            if (ready_q && !rd_i) ovr_d = 1'b1;
        end
        if (frame_bad)
            ferr_d = 1'b1;
    end

`ifdef UART_RX_PARITY_EN
    // remember a parity mismatch so STOP discards the byte
    always_comb begin
        par_err_d = par_err_q;
        if (state_q == ST_START) par_err_d = 1'b0;
        else if (par_bad)        par_err_d = 1'b1;
    end

    // parity error flop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) par_err_q <= 1'b0;
        else         par_err_q <= par_err_d;
    end
`endif

    // datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxs_prev_q <= 1'b1;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            data_q     <= '0;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rxs_prev_q <= rxs_prev_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data_o      = data_q;
    assign rx_ready_o  = ready_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a frame-level model of the receiver.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned D = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic       rxd_i  = 1'b1;
    logic       rd_i   = 1'b0;
    logic [7:0] data_o;
    logic       rx_ready_o, frame_err_o, overrun_o, busy_o;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned lat   = 0;

    // frame-level model of the user-visible registers
    logic [7:0] m_data  = 8'h00;
    logic       m_ready = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;

    uart_rx #(.UART_DIVISOR(D)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rxd_i       (rxd_i),
        .rd_i        (rd_i),
        .data_o      (data_o),
        .rx_ready_o  (rx_ready_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rxd_i = b;
        repeat (D) tick();
    endtask

    // start bit, 8 data bits LSB first, optional parity bit, stop bit; line left at stop level
    task automatic send_frame(input logic [7:0] b, input logic par_bit, input logic stop_bit);
        logic [10:0] f;
        f = (NBITS == 11) ? {stop_bit, par_bit, b, 1'b0} : {1'b0, stop_bit, b, 1'b0};
        for (int i = 0; i < int'(NBITS); i++) drive_bit(f[i]);
    endtask

    task automatic model_good(input logic [7:0] b);
        if (m_ready) m_ovr = 1'b1;
        m_data  = b;
        m_ready = 1'b1;
    endtask

    task automatic model_read();
        m_ready = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic do_read();
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
        model_read();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        rxd_i  = 1'b1;
        repeat (3) tick();
        total++;
        if ({data_o, rx_ready_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
            bad++;
            $display("FAIL reset_hold: got data=%h rdy=%b fe=%b ov=%b busy=%b, want all zero",
                     data_o, rx_ready_o, frame_err_o, overrun_o, busy_o);
        end
        rst_ni = 1'b1;
        repeat (5) tick();
        total++;
        if ({data_o, rx_ready_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
            bad++;
            $display("FAIL reset_idle: got data=%h rdy=%b fe=%b ov=%b busy=%b, want all zero",
                     data_o, rx_ready_o, frame_err_o, overrun_o, busy_o);
        end
    endtask

    task automatic test_frame_55();
        send_frame(8'h55, ^8'h55, 1'b1);
        model_good(8'h55);
        total++;
        if (data_o !== 8'h55 || rx_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL frame55_data: got data=%h rdy=%b, want 55 1", data_o, rx_ready_o);
        end
        total++;
        if (frame_err_o !== 1'b0 || overrun_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL frame55_flags: got fe=%b ov=%b busy=%b, want 0 0 0",
                     frame_err_o, overrun_o, busy_o);
        end
        do_read();
        total++;
        if (rx_ready_o !== 1'b0 || data_o !== 8'h55) begin
            bad++;
            $display("FAIL frame55_read: got rdy=%b data=%h, want 0 55", rx_ready_o, data_o);
        end
    endtask

    task automatic test_glitch();
        rxd_i = 1'b0;
        repeat (3) tick();
        rxd_i = 1'b1;
        repeat (2) tick();
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL glitch_busy: got busy=%b, want 1", busy_o);
        end
        repeat (25) tick();
        total++;
        if (busy_o !== 1'b0 || rx_ready_o !== 1'b0 || frame_err_o !== 1'b0) begin
            bad++;
            $display("FAIL glitch_reject: got busy=%b rdy=%b fe=%b, want 0 0 0",
                     busy_o, rx_ready_o, frame_err_o);
        end
    endtask

    task automatic test_break();
        send_frame(8'hA3, ^8'hA3, 1'b0);
        m_ferr = 1'b1;
        repeat (40) tick();
        total++;
        if (frame_err_o !== 1'b1 || rx_ready_o !== 1'b0 || busy_o !== 1'b1 || data_o !== m_data) begin
            bad++;
            $display("FAIL break_hold: got fe=%b rdy=%b busy=%b data=%h, want 1 0 1 %h",
                     frame_err_o, rx_ready_o, busy_o, data_o, m_data);
        end
        rxd_i = 1'b1;
        repeat (4) tick();
        total++;
        if (busy_o !== 1'b0 || frame_err_o !== 1'b1) begin
            bad++;
            $display("FAIL break_release: got busy=%b fe=%b, want 0 1", busy_o, frame_err_o);
        end
        do_read();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, ^8'h11, 1'b1);
        model_good(8'h11);
        send_frame(8'h22, ^8'h22, 1'b1);
        model_good(8'h22);
        total++;
        if (data_o !== 8'h22 || rx_ready_o !== 1'b1 || overrun_o !== 1'b1 || frame_err_o !== 1'b0) begin
            bad++;
            $display("FAIL overrun_set: got data=%h rdy=%b ov=%b fe=%b, want 22 1 1 0",
                     data_o, rx_ready_o, overrun_o, frame_err_o);
        end
        do_read();
        total++;
        if ({rx_ready_o, frame_err_o, overrun_o} !== 3'b000) begin
            bad++;
            $display("FAIL overrun_clear: got rdy/fe/ov=%b, want 000",
                     {rx_ready_o, frame_err_o, overrun_o});
        end
    endtask

    task automatic test_rd_coincident();
        // find the delivery edge relative to the start bit, with nothing held
        fork
            send_frame(8'h5A, ^8'h5A, 1'b1);
            begin
                lat = 0;
                while (rx_ready_o !== 1'b1 && lat < 400) begin
                    tick();
                    lat++;
                end
            end
        join
        model_good(8'h5A);
        total++;
        if (lat <= (NBITS - 1) * D || lat > NBITS * D) begin
            bad++;
            $display("FAIL deliver_latency: got %0d cycles, want within stop bit (%0d,%0d]",
                     lat, (NBITS - 1) * D, NBITS * D);
            lat = (NBITS - 1) * D + 13;
        end
        // 0x5A still held; read strobe lands exactly on the 0x7E delivery edge
        fork
            send_frame(8'h7E, ^8'h7E, 1'b1);
            begin
                repeat (lat - 1) tick();
                rd_i = 1'b1;
                tick();
                rd_i = 1'b0;
            end
        join
        m_data  = 8'h7E;
        m_ready = 1'b1;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        total++;
        if (data_o !== 8'h7E || rx_ready_o !== 1'b1 || overrun_o !== 1'b0 || frame_err_o !== 1'b0) begin
            bad++;
            $display("FAIL rd_coincident: got data=%h rdy=%b ov=%b fe=%b, want 7e 1 0 0",
                     data_o, rx_ready_o, overrun_o, frame_err_o);
        end
    endtask

    task automatic test_reset_midframe();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rxd_i = 1'b1;
        repeat (5) tick();
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL midframe_busy: got busy=%b, want 1", busy_o);
        end
        rst_ni = 1'b0;
        repeat (2) tick();
        m_data = 8'h00;
        model_read();
        total++;
        if (data_o !== 8'h00 || rx_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL midframe_reset: got data=%h rdy=%b busy=%b, want 00 0 0",
                     data_o, rx_ready_o, busy_o);
        end
        rst_ni = 1'b1;
        repeat (5 * D) tick();
        total++;
        if (data_o !== 8'h00 || rx_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL midframe_after: got data=%h rdy=%b busy=%b, want 00 0 0",
                     data_o, rx_ready_o, busy_o);
        end
        send_frame(8'h0F, ^8'h0F, 1'b1);
        model_good(8'h0F);
        total++;
        if (data_o !== 8'h0F || rx_ready_o !== 1'b1 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            bad++;
            $display("FAIL midframe_next: got data=%h rdy=%b fe=%b ov=%b, want 0f 1 0 0",
                     data_o, rx_ready_o, frame_err_o, overrun_o);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        do_read();
        send_frame(8'h01, 1'b0, 1'b1);
        m_ferr = 1'b1;
        total++;
        if (frame_err_o !== 1'b1 || rx_ready_o !== 1'b0 || data_o !== m_data || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL parity_err: got fe=%b rdy=%b data=%h busy=%b, want 1 0 %h 0",
                     frame_err_o, rx_ready_o, data_o, busy_o, m_data);
        end
        do_read();
    endtask
`endif

    task automatic test_random();
        logic [7:0]  b;
        int unsigned kind;
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 2) == 0) do_read();
            if (kind == 0) begin
                send_frame(b, ^b, 1'b0);
                m_ferr = 1'b1;
                repeat ($urandom_range(0, 20)) tick();
                rxd_i = 1'b1;
                repeat (4) tick();
`ifdef UART_RX_PARITY_EN
            end else if (kind == 1) begin
                send_frame(b, ~^b, 1'b1);
                m_ferr = 1'b1;
`endif
            end else begin
                send_frame(b, ^b, 1'b1);
                model_good(b);
            end
            total++;
            if (data_o !== m_data || rx_ready_o !== m_ready || frame_err_o !== m_ferr ||
                overrun_o !== m_ovr || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL random_%0d kind=%0d byte=%h: got data=%h rdy=%b fe=%b ov=%b busy=%b, want %h %b %b %b 0",
                         n, kind, b, data_o, rx_ready_o, frame_err_o, overrun_o, busy_o,
                         m_data, m_ready, m_ferr, m_ovr);
            end
            repeat ($urandom_range(0, 5)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_frame_55();
        test_glitch();
        test_break();
        test_overrun();
        test_rd_coincident();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter UART_DIVISOR, default 434, meaning clk_i cycles per serial bit (50 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rxd_i  input  1  asynchronous serial line; idle high.
REQ-005 SHALL have port rd_i  input  1  one-cycle read strobe from the bus wrapper; consumes the held byte.
REQ-006 SHALL have port data_o  output  8  last received byte.
REQ-007 SHALL have port rx_ready_o  output  1  unread byte held in data_o.
REQ-008 SHALL have port frame_err_o  output  1  sticky: stop bit (or parity, if enabled) bad.
REQ-009 SHALL have port overrun_o  output  1  sticky: byte completed while rx_ready_o was already 1.
REQ-010 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass rxd_i through a 2-flop synchronizer; all FSM logic uses the synchronized value rxs.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
REQ-013 IDLE: a falling edge of rxs (1 then 0) SHALL enter START with the bit counter cleared.
REQ-014 Sampling in every bit state: samples at counter values H-1, H and H+1 (H = UART_DIVISOR/2, integer); majority vote decided at H+1.
REQ-015 START: vote 1 SHALL return to IDLE (glitch rejected, no flags changed); vote 0 SHALL continue until the counter reaches UART_DIVISOR-1, then enter DATA.
REQ-016 DATA: SHALL shift 8 bits LSB-first, one per UART_DIVISOR cycles (3-bit bit index); after bit 7 enter PARITY (if enabled) else STOP.
REQ-017 STOP: vote 1 SHALL deliver the byte at H+1 and return to IDLE immediately (no wait for the period end).
REQ-018 STOP: vote 0 SHALL set frame_err_o, discard the byte (data_o and rx_ready_o unchanged) and enter BREAK.
REQ-019 BREAK: SHALL remain until rxs is 1, then enter IDLE.
REQ-020 Delivery: data_o loads and rx_ready_o is 1 in the cycle after the deciding sample edge.
REQ-021 Delivery with rx_ready_o already 1 and no rd_i in that cycle: SHALL overwrite data_o and set overrun_o.
REQ-022 rd_i SHALL clear rx_ready_o, frame_err_o and overrun_o on the next edge.
REQ-023 rd_i coincident with a delivery: new byte wins; rx_ready_o stays 1, overrun_o not set, both error flags cleared.
REQ-024 rd_i with rx_ready_o 0 SHALL only clear the flags; it has no other effect.
REQ-025 The bit counter SHALL be $clog2(UART_DIVISOR) bits wide; it clears on every state entry and never wraps inside a state.

Reset
REQ-026 rst_ni low SHALL asynchronously force state IDLE, counter 0, synchronizer flops 1, data_o 8'h00, and all flags and busy_o 0.
REQ-027 Reset mid-frame SHALL discard the partial byte; after release the receiver waits for a fresh falling edge.

Configuration
REQ-028 UART_RX_PARITY_EN defined: SHALL insert the PARITY state after DATA, check even parity with a majority-voted sample, and on mismatch set frame_err_o and discard the byte; the frame still passes through STOP.
REQ-029 UART_RX_PARITY_EN undefined: no PARITY state, no parity logic; frame is 8N1.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum type and the UART_DIVISOR_DEFAULT (434) constant.
REQ-031 Sub-module uart_sync (2-flop synchronizer, reset value 1) SHALL be instantiated once.

Verification (UART_DIVISOR=16 unless stated)
REQ-032 Frame 0x55, 8N1 -> data_o=8'h55, rx_ready_o=1; frame_err_o=0; overrun_o=0.
REQ-033 rxd_i low for 3 cycles, then high -> returns to IDLE; rx_ready_o stays 0; busy_o drops.
REQ-034 Frame 0xA3 with stop bit 0, line held low 40 cycles -> frame_err_o=1, rx_ready_o=0, busy_o held high until line high.
REQ-035 Frames 0x11 then 0x22, no rd_i -> data_o=8'h22, rx_ready_o=1, overrun_o=1; rd_i -> all flags 0.
REQ-036 rd_i in the delivery cycle of 0x7E -> rx_ready_o=1, overrun_o=0, data_o=8'h7E.
REQ-037 rst_ni pulsed low during bit 4 of 0xFF -> data_o=0, rx_ready_o=0; next frame 0x0F received correctly; with UART_RX_PARITY_EN, 0x01 with parity 0 -> frame_err_o=1.
